// File: rtl/rx_asm_pkg.sv
// Shared types for the serial debug receive-word assembler.
// Holds the FSM state encoding and transfer-type codes.
package rx_asm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam logic TYPE_BYTE = 1'b0;
   localparam logic TYPE_WORD = 1'b1;

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle timer: loads LIMIT-1 on clear and counts down.
// expire is high once the count has reached zero.
module rx_idle_timer
   import rx_asm_pkg::*;
#(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

   logic [W-1:0] count;

   // reload on every accepted byte, saturate at zero while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= LOAD;
      else if (clear)
         count <= LOAD;
      else if (en && count != '0)
         count <= count - W'(1);
   end

   assign expire = (count == '0);

endmodule

// File: rtl/rx_word_assembler.sv
// Receive-side byte-to-word assembler for the serial debug unit.
// Collects UART bytes into single bytes or DW_BYTES-wide words.
module rx_word_assembler
   import rx_asm_pkg::*;
#(
   parameter int DW_BYTES   = 4,
   parameter bit BIG_ENDIAN = 1'b0,
   parameter int TIMEOUT    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic [7:0]                    in_data,
   input  logic                          in_type,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [8*DW_BYTES-1:0]         out_data,
   output logic                          out_type,
   output logic [$clog2(DW_BYTES+1)-1:0] out_cnt,
   output logic                          out_err,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int CW = $clog2(DW_BYTES + 1);
   localparam int OW = 8 * DW_BYTES;

   state_t          state;
   logic            accept;
   logic            expire;
   logic [CW-1:0]   lane_idx;
   logic [CW-1:0]   lane;

   // both handshakes decode from registered state only
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   // lane for the incoming byte; out_cnt doubles as the byte counter
   always_comb begin
      lane_idx = (state == IDLE) ? '0 : out_cnt;
      lane     = BIG_ENDIAN ? (CW'(DW_BYTES - 1) - lane_idx) : lane_idx;
   end

   function automatic logic [OW-1:0] place(input logic [7:0]    b,
                                           input logic [CW-1:0] l);
      logic [OW-1:0] w;
      w = '0;
      for (int i = 0; i < DW_BYTES; i++)
         if (int'(l) == i)
            w[8*i +: 8] = b;
      return w;
   endfunction

   generate
      if (TIMEOUT > 0) begin : g_timer
         logic timer_clear;
         logic timer_en;
         assign timer_clear = clr || accept;
         assign timer_en    = (state == COLLECT) && !accept;
         rx_idle_timer #(
            .LIMIT (TIMEOUT)
         ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .clear  (timer_clear),
            .en     (timer_en),
            .expire (expire)
         );
      end else begin : g_no_timer
         assign expire = 1'b0;
      end
   endgenerate

   // transfer FSM: clr beats every other event, an accepted byte beats expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         out_data <= '0;
         out_type <= TYPE_BYTE;
         out_cnt  <= '0;
         out_err  <= 1'b0;
      end else if (clr) begin
         state    <= IDLE;
         out_data <= '0;
         out_type <= TYPE_BYTE;
         out_cnt  <= '0;
         out_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  out_type <= in_type;
                  out_err  <= 1'b0;
                  out_cnt  <= CW'(1);
                  if (in_type == TYPE_WORD) begin
                     out_data <= place(in_data, lane);
                     state    <= COLLECT;
                  end else begin
                     out_data <= OW'(in_data);
                     state    <= HOLD;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  out_data <= out_data | place(in_data, lane);
                  out_cnt  <= out_cnt + CW'(1);
                  if (out_cnt == CW'(DW_BYTES - 1))
                     state <= HOLD;
               end else if (expire) begin
                  out_err <= 1'b1;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
